clk_div_multi: RTL

- Parametrised, multi-channel successor to the single fixed-ratio clock divider.
- Generates NUM_CH independent divided outputs from one system clock. Each channel has:
  - a divisor loadable at runtime,
  - a per-channel enable,
  - a selectable output mode: 50% toggle clock, or one-cycle tick strobe.
- Feeds the game's timing consumers (VGA pixel tick, laser/target movement ticks, debounce sampling, seven-segment refresh) from one block.
- A global sync input re-aligns all channels.

---
 rtl/clk_div_multi.sv | 93 +++++++++
 1 files changed

// File: rtl/clk_div_multi.sv
// Multi-channel runtime-programmable clock divider: per-channel toggle clock or tick strobe,
// glitch-free divisor reload at terminal count, and a global phase-realign strobe.
module clk_div_multi #(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned CNT_W       = 20,
  parameter int unsigned DEFAULT_DIV = 4999
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [NUM_CH-1:0] i_en,
  input  logic [NUM_CH-1:0] i_mode,
  input  logic [NUM_CH-1:0] i_div_wr,
  input  logic [CNT_W-1:0]  i_div_val,
  input  logic              i_sync,
  output logic [NUM_CH-1:0] o_clk_d,
  output logic [NUM_CH-1:0] o_tick,
  output logic [NUM_CH-1:0] o_pending
);

  localparam logic [CNT_W-1:0] DefDiv = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_div;
    logic [CNT_W-1:0] r_shadow;
    logic             r_clk_d;
    logic             r_tick;
    logic             r_pending;
    logic             w_term;
    logic             w_apply;

    // >= also catches a count left above a divisor that was shrunk while disabled.
    assign w_term  = (r_cnt >= r_div);
    assign w_apply = ~i_en[g] | w_term;

    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        r_cnt     <= '0;
        r_div     <= DefDiv;
        r_shadow  <= '0;
        r_clk_d   <= 1'b0;
        r_tick    <= 1'b0;
        r_pending <= 1'b0;
      end else if (i_sync) begin
        r_cnt     <= '0;
        r_clk_d   <= 1'b0;
        r_tick    <= 1'b0;
        r_pending <= 1'b0;
        if (i_div_wr[g]) begin
          r_div    <= i_div_val;
          r_shadow <= i_div_val;
        end else if (r_pending) begin
          r_div <= r_shadow;
        end
      end else begin
        // A new divisor only lands at a period boundary (or while idle) to avoid runt periods.
        if (i_div_wr[g]) begin
          r_shadow <= i_div_val;
          if (w_apply) begin
            r_div     <= i_div_val;
            r_pending <= 1'b0;
          end else begin
            r_pending <= 1'b1;
          end
        end else if (r_pending && w_apply) begin
          r_div     <= r_shadow;
          r_pending <= 1'b0;
        end

        if (i_en[g]) begin
          if (w_term) begin
            r_cnt   <= '0;
            r_tick  <= 1'b1;
            r_clk_d <= i_mode[g] ? 1'b1 : ~r_clk_d;
          end else begin
            r_cnt  <= r_cnt + CntOne;
            r_tick <= 1'b0;
            if (i_mode[g]) r_clk_d <= 1'b0;
          end
        end else begin
          r_tick <= 1'b0;
          if (i_mode[g]) r_clk_d <= 1'b0;
        end
      end
    end

    assign o_clk_d[g]   = r_clk_d;
    assign o_tick[g]    = r_tick;
    assign o_pending[g] = r_pending;
  end

endmodule
